// File: rtl/aes_key_expand.sv
// AES-128 key schedule, one word per clock.
// Expands a 128-bit cipher key into the 44-word schedule (11 round keys).
// Previously written words are read back from the round-key register
// itself, so no separate word storage is needed.
module aes_key_expand (
  input  logic          clk,
  input  logic          resetn,
  input  logic [127:0]  key_in,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          key_valid,
  output logic [1407:0] roundkey
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t         state_r, state_s;
  logic [5:0]     i_r, i_s;
  logic [1407:0]  rk_r, rk_s;
  logic           done_r, done_s;
  logic           kv_r, kv_s;
  logic [31:0]    w_prev_s, w_back_s, rot_s, temp_s, w_new_s;

  // Byte substitution through the S-box table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx  = 11'd2047 - {b, 3'b000};
    sbox = SBOX_TABLE[idx -: 8];
  endfunction

  // SubWord: four parallel S-box lookups.
  function automatic logic [31:0] subword(input logic [31:0] w);
    subword = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant for schedule round n (n = i/4).
  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Bit offset of the low end of word k: round k/4, word k%4 counted from the top.
  function automatic logic [10:0] word_off(input logic [5:0] k);
    word_off = {k[5:2], 7'b0000000} + 11'd96 - {4'b0000, k[1:0], 5'b00000};
  endfunction

  // Next schedule word from w[i-1] and w[i-4] read back out of the register.
  always_comb begin
    w_prev_s = rk_r[word_off(i_r - 6'd1) +: 32];
    w_back_s = rk_r[word_off(i_r - 6'd4) +: 32];
    rot_s    = {w_prev_s[23:0], w_prev_s[31:24]};
    if (i_r[1:0] == 2'b00) begin
      temp_s = subword(rot_s) ^ {rcon(i_r[5:2]), 24'h000000};
    end else begin
      temp_s = w_prev_s;
    end
    w_new_s = w_back_s ^ temp_s;
  end

  // Next-state and next-output decode for the IDLE/EXPAND controller.
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    rk_s    = rk_r;
    done_s  = 1'b0;
    kv_s    = kv_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          rk_s    = {{1280{1'b0}}, key_in};
          i_s     = 6'd4;
          kv_s    = 1'b0;
          state_s = ST_EXPAND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        rk_s[word_off(i_r) +: 32] = w_new_s;
        if (i_r == 6'd43) begin
          done_s  = 1'b1;
          kv_s    = 1'b1;
          i_s     = 6'd4;
          state_s = ST_IDLE;
        end else begin
          i_s     = i_r + 6'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        i_s     = 6'd4;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      i_r     <= 6'd4;
      rk_r    <= {1408{1'b0}};
      done_r  <= 1'b0;
      kv_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      rk_r    <= rk_s;
      done_r  <= done_s;
      kv_r    <= kv_s;
    end
  end

  assign busy      = (state_r == ST_EXPAND);
  assign done      = done_r;
  assign key_valid = kv_r;
  assign roundkey  = rk_r;

endmodule
